mseq_gen_param: RTL and testbench

Parametrised maximal-length (M-sequence) PN code generator, the next generation of the fixed 6-bit generator.
- LFSR width, polynomial, seed, chip hold and period count are all configurable.
- Code phase is reached by stepping the LFSR in an ALIGN state instead of using a lookup table.
- Sits between the code-configuration controller (valid/ready config port) and the modulator/DSP datapath (chip stream plus strobes).

---
 rtl/mseq_pkg.sv | 33 +++
 rtl/mseq_lfsr_core.sv | 55 +++++
 rtl/mseq_gen_param.sv | 196 +++++++++++++++++++
 tb/tb_mseq_gen_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
// -----------------------------------------------------------------------------
// mseq_pkg
// Shared types and helpers for the parametrised M-sequence generator.
//   state_t      : generator FSM states (IDLE, ALIGN, RUN)
//   lfsr_step()  : one Fibonacci LFSR step on a width-generic vector
//   code_period(): code period N = 2^length - 1
// -----------------------------------------------------------------------------
package mseq_pkg;

   // Widest LFSR the generic step function supports.
   localparam int unsigned MAX_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      RUN
   } state_t;

   // state/poly are zero-extended to MAX_W by the caller, so the unused upper
   // bits never contribute to the feedback parity.
   function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                  input logic [MAX_W-1:0] poly,
                                                  input int unsigned      length);
      logic fb;
      fb = ^(poly & state);
      return (state >> 1) | (MAX_W'(fb) << (length - 1));
   endfunction

   function automatic int unsigned code_period(input int unsigned length);
      return (32'd1 << length) - 32'd1;
   endfunction

endpackage

// File: rtl/mseq_lfsr_core.sv
// -----------------------------------------------------------------------------
// mseq_lfsr_core
// LENGTH-bit Fibonacci LFSR with synchronous load of SEED and step enable.
// Ports:
//   clkin        in   clock
//   rstn         in   synchronous active-low reset (state <= SEED)
//   load_i       in   load SEED (has priority over step_i)
//   step_i       in   advance the LFSR by one step
//   chip_o       out  current chip, state[0]
//   chip_next_o  out  chip that appears after the next step
// -----------------------------------------------------------------------------
module mseq_lfsr_core
   import mseq_pkg::*;
#(
   parameter int unsigned       LENGTH = 6,
   parameter logic [LENGTH-1:0] POLY   = 6'b100111,
   parameter logic [LENGTH-1:0] SEED   = LENGTH'(1)
) (
   input  logic clkin,
   input  logic rstn,
   input  logic load_i,
   input  logic step_i,
   output logic chip_o,
   output logic chip_next_o
);

   logic [LENGTH-1:0] state_q;
   logic [LENGTH-1:0] state_d;
   logic [LENGTH-1:0] step_val;

   always_comb begin
      step_val = LENGTH'(lfsr_step(MAX_W'(state_q), MAX_W'(POLY), LENGTH));
   end

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = SEED;
      end else if (step_i) begin
         state_d = step_val;
      end
   end

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign chip_o      = state_q[0];
   assign chip_next_o = step_val[0];

endmodule

// File: rtl/mseq_gen_param.sv
// -----------------------------------------------------------------------------
// mseq_gen_param
// Parametrised maximal-length PN code generator. A configuration (phase, chip
// hold, period count) is accepted over a valid/ready port; the code phase is
// reached by stepping the LFSR in ALIGN, then chips are emitted in RUN.
// Ports:
//   clkin         in   clock
//   rstn          in   synchronous active-low reset
//   cfg_valid     in   configuration request
//   cfg_ready     out  idle, configuration can be accepted
//   cfg_shift     in   code phase offset in chips (N treated as 0)
//   cfg_hold      in   extra cycles per chip (chip lasts cfg_hold+1 cycles)
//   cfg_periods   in   full periods to emit, 0 = continuous
//   stop          in   synchronous abort (ignored in IDLE)
//   chip_o        out  current chip
//   chip_valid_o  out  chip_o meaningful
//   chip_stb_o    out  pulse on first cycle of every chip
//   strobe_o      out  pulse on first cycle of chip 0 of each period
//   done_o        out  pulse when the final period completes
// All outputs are registered.
// -----------------------------------------------------------------------------
module mseq_gen_param
   import mseq_pkg::*;
#(
   parameter int unsigned       LENGTH = 6,
   parameter logic [LENGTH-1:0] POLY   = 6'b100111,
   parameter logic [LENGTH-1:0] SEED   = LENGTH'(1),
   parameter int unsigned       HOLD_W = 4,
   parameter int unsigned       PER_W  = 8
) (
   input  logic              clkin,
   input  logic              rstn,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [LENGTH-1:0] cfg_shift,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic [PER_W-1:0]  cfg_periods,
   input  logic              stop,
   output logic              chip_o,
   output logic              chip_valid_o,
   output logic              chip_stb_o,
   output logic              strobe_o,
   output logic              done_o
);

   localparam logic [LENGTH-1:0] LAST_CHIP = LENGTH'(code_period(LENGTH) - 1);
   localparam logic [LENGTH-1:0] FULL_PER  = LENGTH'(code_period(LENGTH));

   state_t            state_q;
   logic [LENGTH-1:0] align_cnt_q;
   logic [LENGTH-1:0] chip_cnt_q;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [PER_W-1:0]  periods_q;
   logic [PER_W-1:0]  per_cnt_q;

   logic ready_q;
   logic chip_q;
   logic valid_q;
   logic stb_q;
   logic strobe_q;
   logic done_q;

   logic lfsr_chip;
   logic lfsr_chip_next;
   logic load_lfsr;
   logic step_lfsr;
   logic last_chip;
   logic hold_exp;
   logic final_chip;

   // In RUN the LFSR holds the state of the chip currently on chip_o; it steps
   // on the edge that puts the next chip on the output.
   always_comb begin
      last_chip  = (chip_cnt_q == LAST_CHIP);
      hold_exp   = (state_q == RUN) && valid_q && (hold_cnt_q == '0);
      final_chip = hold_exp && last_chip && (periods_q != '0) &&
                   (per_cnt_q == periods_q - PER_W'(1));
      load_lfsr  = (state_q == IDLE) && cfg_valid;
      step_lfsr  = !stop && ((state_q == ALIGN) || (hold_exp && !final_chip));
   end

   mseq_lfsr_core #(
      .LENGTH (LENGTH),
      .POLY   (POLY),
      .SEED   (SEED)
   ) u_lfsr (
      .clkin       (clkin),
      .rstn        (rstn),
      .load_i      (load_lfsr),
      .step_i      (step_lfsr),
      .chip_o      (lfsr_chip),
      .chip_next_o (lfsr_chip_next)
   );

   always_ff @(posedge clkin) begin
      if (!rstn) begin
         state_q     <= IDLE;
         align_cnt_q <= '0;
         chip_cnt_q  <= '0;
         hold_q      <= '0;
         hold_cnt_q  <= '0;
         periods_q   <= '0;
         per_cnt_q   <= '0;
         ready_q     <= 1'b1;
         chip_q      <= 1'b0;
         valid_q     <= 1'b0;
         stb_q       <= 1'b0;
         strobe_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         stb_q    <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               chip_q  <= 1'b0;
               valid_q <= 1'b0;
               if (cfg_valid) begin
                  ready_q     <= 1'b0;
                  hold_q      <= cfg_hold;
                  periods_q   <= cfg_periods;
                  align_cnt_q <= cfg_shift;
                  if ((cfg_shift == '0) || (cfg_shift == FULL_PER)) begin
                     state_q <= RUN;
                  end else begin
                     state_q <= ALIGN;
                  end
               end
            end

            ALIGN: begin
               if (stop) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end else if (align_cnt_q == LENGTH'(1)) begin
                  state_q <= RUN;
               end else begin
                  align_cnt_q <= align_cnt_q - LENGTH'(1);
               end
            end

            RUN: begin
               if (stop) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  chip_q  <= 1'b0;
                  valid_q <= 1'b0;
               end else if (!valid_q) begin
                  // First RUN cycle: present chip 0 of the first period.
                  valid_q    <= 1'b1;
                  chip_q     <= lfsr_chip;
                  stb_q      <= 1'b1;
                  strobe_q   <= 1'b1;
                  hold_cnt_q <= hold_q;
                  chip_cnt_q <= '0;
                  per_cnt_q  <= '0;
               end else if (hold_cnt_q != '0) begin
                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
               end else if (final_chip) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  chip_q  <= 1'b0;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  chip_q     <= lfsr_chip_next;
                  stb_q      <= 1'b1;
                  strobe_q   <= last_chip;
                  hold_cnt_q <= hold_q;
                  chip_cnt_q <= last_chip ? '0 : chip_cnt_q + LENGTH'(1);
                  if (last_chip && (periods_q != '0)) begin
                     per_cnt_q <= per_cnt_q + PER_W'(1);
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               chip_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready    = ready_q;
   assign chip_o       = chip_q;
   assign chip_valid_o = valid_q;
   assign chip_stb_o   = stb_q;
   assign strobe_o     = strobe_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_mseq_gen_param.sv
// -----------------------------------------------------------------------------
// tb_mseq_gen_param
// Self-checking bench for mseq_gen_param with default geometry (6-bit LFSR).
// Each vector row drives one configuration; the expected output trace is
// generated from a reference LFSR and queued when the configuration is driven,
// then popped and compared one record per clock.
// -----------------------------------------------------------------------------
module tb_mseq_gen_param;

   localparam int unsigned N       = 63;
   localparam logic [5:0]  POLY_TB = 6'b100111;
   localparam logic [5:0]  SEED_TB = 6'd1;

   typedef struct packed {
      logic ready;
      logic valid;
      logic chip;
      logic stb;
      logic strobe;
      logic done;
   } out_t;

   typedef struct {
      int shift;
      int hold;
      int periods;
      int stop_at;       // record index at which stop takes effect, 0 = none
      int poke_at;       // edge index of a cfg_valid pulse while busy, 0 = none
      int stop_with_cfg; // drive stop together with cfg_valid in IDLE
   } vec_t;

   logic       clkin = 1'b0;
   logic       rstn  = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [5:0] cfg_shift = '0;
   logic [3:0] cfg_hold = '0;
   logic [7:0] cfg_periods = '0;
   logic       stop = 1'b0;
   logic       chip_o;
   logic       chip_valid_o;
   logic       chip_stb_o;
   logic       strobe_o;
   logic       done_o;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[10];

   always #5 clkin = ~clkin;

   mseq_gen_param #(
      .LENGTH (6),
      .POLY   (6'b100111),
      .SEED   (6'd1),
      .HOLD_W (4),
      .PER_W  (8)
   ) dut (
      .clkin        (clkin),
      .rstn         (rstn),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_shift    (cfg_shift),
      .cfg_hold     (cfg_hold),
      .cfg_periods  (cfg_periods),
      .stop         (stop),
      .chip_o       (chip_o),
      .chip_valid_o (chip_valid_o),
      .chip_stb_o   (chip_stb_o),
      .strobe_o     (strobe_o),
      .done_o       (done_o)
   );

   function automatic logic [5:0] ref_step(input logic [5:0] s);
      logic [5:0] taps;
      logic       fb;
      taps = POLY_TB;
      fb   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (taps[i]) fb = fb ^ s[i];
      end
      return {fb, s[5:1]};
   endfunction

   function automatic out_t mk(input logic r, input logic v, input logic c,
                               input logic sb, input logic st, input logic d);
      out_t o;
      o.ready = r; o.valid = v; o.chip = c; o.stb = sb; o.strobe = st; o.done = d;
      return o;
   endfunction

   function automatic out_t dut_out();
      return mk(cfg_ready, chip_valid_o, chip_o, chip_stb_o, strobe_o, done_o);
   endfunction

   function automatic bit stop_here(input vec_t v, input int j);
      return (v.stop_at != 0) && (j == v.stop_at);
   endfunction

   // Expected outputs sampled after edges k, k+1, ... where k accepts the config.
   task automatic build_trace(input vec_t v);
      logic [5:0] m;
      int         j;
      int         s_eff;
      out_t       idle;
      m     = SEED_TB;
      j     = 0;
      s_eff = v.shift % N;
      idle  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int a = 0; a <= s_eff; a++) begin
         if (stop_here(v, j)) begin exp_q.push_back(idle); return; end
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         j++;
         if (a < s_eff) m = ref_step(m);
      end
      for (int p = 0; (v.periods == 0 && v.stop_at != 0) || p < v.periods; p++) begin
         for (int c = 0; c < N; c++) begin
            for (int h = 0; h <= v.hold; h++) begin
               if (stop_here(v, j)) begin exp_q.push_back(idle); return; end
               exp_q.push_back(mk(1'b0, 1'b1, m[0], h == 0, (h == 0) && (c == 0), 1'b0));
               j++;
            end
            m = ref_step(m);
         end
      end
      if (stop_here(v, j)) begin exp_q.push_back(idle); return; end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(idle);
   endtask

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: ready,valid,chip,stb,strobe,done got %b expected %b",
                  name, act, exp);
      end
   endtask

   // Entered and left at a negedge.
   task automatic run_vec(input vec_t v, input string tag);
      int waitc;
      int j;
      waitc = 0;
      while (cfg_ready !== 1'b1 && waitc < 20) begin
         @(negedge clkin);
         waitc++;
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: cfg_ready got %b expected 1", tag, cfg_ready);
         return;
      end
      cfg_shift   = 6'(v.shift);
      cfg_hold    = 4'(v.hold);
      cfg_periods = 8'(v.periods);
      cfg_valid   = 1'b1;
      stop        = (v.stop_with_cfg != 0);
      build_trace(v);
      j = 0;
      while (exp_q.size() > 0) begin
         @(negedge clkin);
         check($sformatf("%s cyc%0d", tag, j), dut_out(), exp_q.pop_front());
         cfg_valid = (v.poke_at != 0) && (j + 1 == v.poke_at);
         if (cfg_valid) begin
            cfg_shift   = 6'd7;
            cfg_hold    = 4'd9;
            cfg_periods = 8'd3;
         end
         stop = (v.stop_at != 0) && (j + 1 == v.stop_at);
         j++;
      end
      stop      = 1'b0;
      cfg_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                shift hold per stop_at poke stop_with_cfg
      vecs[0] = '{0,  0,  1, 0,   0,  0}; // plain single period
      vecs[1] = '{2,  0,  1, 0,   0,  0}; // phase offset 2
      vecs[2] = '{0,  2,  2, 0,   0,  0}; // hold 2, two periods
      vecs[3] = '{0,  0,  0, 100, 0,  0}; // continuous, stopped
      vecs[4] = '{63, 0,  1, 0,   30, 0}; // shift==N, busy cfg_valid pulse
      vecs[5] = '{1,  1,  1, 0,   0,  1}; // stop with cfg_valid in IDLE
      vecs[6] = '{0,  0,  1, 64,  0,  0}; // stop on final expiry
      vecs[7] = '{40, 0,  0, 10,  0,  0}; // stop during ALIGN
      vecs[8] = '{62, 3,  1, 0,   0,  0}; // largest real shift
      vecs[9] = '{5,  15, 1, 0,   0,  0}; // largest hold

      repeat (3) @(negedge clkin);
      check("reset_hold", dut_out(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      rstn = 1'b1;
      @(negedge clkin);
      check("reset_release", dut_out(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of ALIGN (shift 40, 10 cycles in).
      cfg_shift   = 6'd40;
      cfg_hold    = 4'd0;
      cfg_periods = 8'd1;
      cfg_valid   = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clkin);
         cfg_valid = 1'b0;
         check($sformatf("rst_align cyc%0d", j), dut_out(),
               mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      rstn = 1'b0;
      @(negedge clkin);
      check("rst_mid_align", dut_out(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      rstn = 1'b1;
      @(negedge clkin);
      check("rst_after", dut_out(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_vec(vecs[0], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
